noc_port_tx: RTL and testbench
==============================

# noc_port_tx

Injection-side port controller for the NoC crossbar: it buffers flits from a local producer and presents each one to a crossbar input port as a `dest` request mask with data. It holds the request until every destination bit has been acknowledged on `ack`, supporting multicast. There is one instance per crossbar input port, sitting between the local core interface and the crossbar's `dest`/`data_i`/`ack` signals.

## Interface
- `PORTS`, 4, crossbar port count; width of the destination mask and of `ack`.
- `WIDTH`, 8, flit data width.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  producer offers a flit.
- `in_ready`  out  1  block can accept; reset 1.
- `in_data`  in  WIDTH  flit payload.
- `in_dest`  in  PORTS  destination mask; multiple bits mean multicast.
- `dest`  out  PORTS  request mask to the crossbar; reset 0.
- `data_o`  out  WIDTH  flit to the crossbar `data_i`; reset 0.
- `ack`  in  PORTS  per-destination grant from the crossbar, sampled each cycle.
- `busy`  out  1  FSM in REQ; reset 0.
- `sent`  out  1  one-cycle pulse when a flit has been fully delivered; reset 0.

## Operation
- **Accept**
  - Occurs when `in_valid && in_ready` at a rising edge.
  - `in_ready = (count != DEPTH)`. It does not account for a same-cycle pop.
  - A flit with `in_dest == 0` is consumed but not stored (dropped).
- **FIFO**
  - Circular buffer holding `{dest, data}` entries.
  - Read and write pointers are `$clog2(DEPTH)` bits and wrap naturally.
  - `count` is `$clog2(DEPTH)+1` bits.
  - A simultaneous push and pop leaves `count` unchanged.
- **FSM states: IDLE, REQ**
  - **IDLE**
    - `dest = 0` and `data_o = 0`.
    - If `count > 0`: load `pending <= head.dest` and go to REQ.
  - **REQ**
    - `dest = pending` and `data_o = head.data`.
    - Each edge: `pending <= pending & ~ack`.
    - `ack` bits outside `pending` are ignored.
    - If `(pending & ~ack) == 0`: pop the head, pulse `sent`, then:
      - if an entry remains after the pop (`count > 1`), load its dest into `pending` and stay in REQ (back-to-back);
      - otherwise go to IDLE.
- `data_o` is stable for the whole life of a flit. The head entry is never modified.
- Partial acks shrink `dest` on the following cycle. Destinations that have already acked are never re-requested.
- **Reset mid-operation:** pending flits are discarded, pointers and `count` go to 0, and the FSM returns to IDLE.

## Timing
- A flit accepted at edge N into an empty FIFO with the FSM in IDLE is loaded at edge N+1. `dest` and `data_o` are valid after edge N+1.
- With `ack` equal to the full mask in that cycle:
  - the pop occurs at edge N+2;
  - `sent` is high for the cycle following edge N+2.
- Back-to-back flits: one flit per cycle with single-cycle acks, with no IDLE bubble between them.
- `ack` is sampled combinationally into the next-state logic. There is no combinational path from `ack` to `dest`.
- All outputs are registered or decoded from registered state only.

## Configuration
- **`NOC_TX_STATS_EN` defined:** adds two outputs, both reset to 0, 16-bit saturating at `16'hFFFF`.
  - `sent_cnt`: increments on each `sent` pulse.
  - `drop_cnt`: increments on each accepted flit with `in_dest == 0`.
- **Undefined:** the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `noc_pkg` contains:
  - `PORTS`/`WIDTH` defaults;
  - `typedef logic [PORTS-1:0] noc_mask_t`;
  - the flit struct `{noc_mask_t dest; logic [WIDTH-1:0] data}`;
  - the FSM state enum `noc_tx_state_e {IDLE, REQ}`.
- One sub-module, `noc_flit_fifo`: parameterised sync FIFO with push/pop, `count`, and head output. The FSM and ack masking live in `noc_port_tx`.

## Test plan
- **Unicast:** push `data=0x42`, `in_dest=0001`; drive `ack=0001` when `dest` appears.
  - Required: `dest=0001`, `data_o=0x42` for exactly one cycle.
  - Then `sent` pulses and `dest` returns to `0000`.
- **Multicast with partial acks:** push `0x20` with dest `1011`.
  - `ack=0001`: next cycle `dest=1010`.
  - `ack=1000`: next cycle `dest=0010`.
  - `ack=0010`: `sent` pulses once; `data_o` stays `0x20` throughout.
- **Spurious ack:** push dest `0100`; hold `ack=1011` for 3 cycles, then `ack=0100`.
  - Required: `dest` stays `0100` until the final ack; exactly one `sent`.
- **FIFO full / wrap:** with `ack=0`, push 5 flits at `DEPTH=4`.
  - Required: `in_ready` drops after the 4th accept and the 5th waits.
  - Then drive `ack=1111` continuously: flits leave in order, one per cycle with no bubble, across pointer wrap.
- **Drop:** push `in_dest=0000`.
  - Required: `in_ready` stays 1, `dest` stays 0, no `sent`.
  - With `NOC_TX_STATS_EN`: `drop_cnt=1`.
- **Reset mid-flight:** queue 3 flits, assert `rst_n=0` during REQ.
  - Required: immediately `dest=0`, `busy=0`, `in_ready=1`.
  - After release, no stale flit is ever presented.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC types: default port/data widths, flit layout and port-TX FSM states.
package noc_pkg;

  localparam int NOC_PORTS = 4;
  localparam int NOC_WIDTH = 8;
  localparam int NOC_DEPTH = 4;

  typedef logic [NOC_PORTS-1:0] noc_mask_t;

  typedef struct packed {
    noc_mask_t            dest;
    logic [NOC_WIDTH-1:0] data;
  } noc_flit_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } noc_tx_state_e;

endpackage

// File: rtl/noc_flit_fifo.sv
// Circular-buffer sync FIFO of flits; exposes the head and the entry behind it.
module noc_flit_fifo
  import noc_pkg::*;
#(
  parameter type flit_t = noc_flit_t,
  parameter int  DEPTH  = NOC_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  flit_t                  wr_flit,
  input  logic                   pop,
  output flit_t                  head,
  output flit_t                  head_next,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  flit_t           mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_pop;

  assign do_pop = pop && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_flit;
  end

  assign head      = mem[rd_ptr_q];
  assign head_next = mem[rd_ptr_q + AW'(1)];
  assign count     = count_q;

endmodule

// File: rtl/noc_port_tx.sv
// Crossbar injection port: queues flits and holds each multicast request until all dests ack.
// Optional NOC_TX_STATS_EN adds saturating sent/drop counters.
module noc_port_tx
  import noc_pkg::*;
#(
  parameter int PORTS = NOC_PORTS,
  parameter int WIDTH = NOC_WIDTH,
  parameter int DEPTH = NOC_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [PORTS-1:0] in_dest,
  output logic [PORTS-1:0] dest,
  output logic [WIDTH-1:0] data_o,
  input  logic [PORTS-1:0] ack,
  output logic             busy,
  output logic             sent
`ifdef NOC_TX_STATS_EN
  ,
  output logic [15:0]      sent_cnt,
  output logic [15:0]      drop_cnt
`endif
);

  // state | meaning
  // IDLE  | nothing presented; load pending from head when FIFO non-empty
  // REQ   | head presented with remaining (un-acked) destination mask
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [PORTS-1:0] dest;
    logic [WIDTH-1:0] data;
  } flit_t;

  noc_tx_state_e    state_q, state_d;
  logic [PORTS-1:0] pending_q, pending_d;
  logic [PORTS-1:0] remaining;
  logic             sent_q, sent_d;
  logic             accept, push, pop;
  flit_t            wr_flit, head, head_next;
  logic [CW-1:0]    count;

  assign in_ready = (count != CW'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign push     = accept && (in_dest != '0);
  assign wr_flit  = '{dest: in_dest, data: in_data};

  noc_flit_fifo #(
    .flit_t (flit_t),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .wr_flit   (wr_flit),
    .pop       (pop),
    .head      (head),
    .head_next (head_next),
    .count     (count)
  );

  assign remaining = pending_q & ~ack;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    pop       = 1'b0;
    sent_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          pending_d = head.dest;
          state_d   = REQ;
        end
      end
      REQ: begin
        pending_d = remaining;
        if (remaining == '0) begin
          pop    = 1'b1;
          sent_d = 1'b1;
          // A same-cycle push is not counted here, so it waits for IDLE.
          if (count > CW'(1)) pending_d = head_next.dest;
          else state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      sent_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      sent_q    <= sent_d;
    end
  end

  assign busy   = (state_q == REQ);
  assign dest   = busy ? pending_q : '0;
  assign data_o = busy ? head.data : '0;
  assign sent   = sent_q;

`ifdef NOC_TX_STATS_EN
  logic [15:0] sent_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sent_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (sent_d && (sent_cnt_q != 16'hFFFF)) sent_cnt_q <= sent_cnt_q + 16'd1;
      if (accept && (in_dest == '0) && (drop_cnt_q != 16'hFFFF))
        drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign sent_cnt = sent_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_noc_port_tx.sv
// Bench for noc_port_tx: directed scenarios plus random traffic against a queue-based model.
module tb_noc_port_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [3:0] in_dest;
  logic [3:0] dest;
  logic [7:0] data_o;
  logic [3:0] ack;
  logic       busy;
  logic       sent;
`ifdef NOC_TX_STATS_EN
  logic [15:0] sent_cnt, drop_cnt;
`endif

  noc_port_tx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_dest  (in_dest),
    .dest     (dest),
    .data_o   (data_o),
    .ack      (ack),
    .busy     (busy),
    .sent     (sent)
`ifdef NOC_TX_STATS_EN
    ,
    .sent_cnt (sent_cnt),
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  // Model: queue of {dest,data}; the front entry is presented with the mask still owed.
  logic [11:0] q[$];
  bit          pres;
  logic [3:0]  rem;
  bit          sent_exp;
  bit          acc_last;
  int          sents_m, drops_m;

  task automatic model_reset();
    q.delete();
    pres     = 0;
    rem      = '0;
    sent_exp = 0;
    sents_m  = 0;
    drops_m  = 0;
  endtask

  task automatic model_edge();
    int sz;
    bit acc;
    sz       = q.size();
    acc      = in_valid && (sz != 4);
    sent_exp = 0;
    if (pres) begin
      rem = rem & ~ack;
      if (rem == 4'h0) begin
        sent_exp = 1;
        sents_m++;
        q.delete(0);
        if (sz > 1) rem = q[0][11:8];
        else pres = 0;
      end
    end else if (sz > 0) begin
      pres = 1;
      rem  = q[0][11:8];
    end
    if (acc) begin
      if (in_dest == 4'h0) drops_m++;
      else q.push_back({in_dest, in_data});
    end
    acc_last = acc;
  endtask

  task automatic compare_outputs();
    check("dest",     32'(dest),     pres ? 32'(rem) : 32'h0);
    check("data_o",   32'(data_o),   pres ? 32'(q[0][7:0]) : 32'h0);
    check("busy",     32'(busy),     32'(pres));
    check("sent",     32'(sent),     32'(sent_exp));
    check("in_ready", 32'(in_ready), 32'(q.size() != 4));
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic [3:0] m, input logic [3:0] a);
    in_valid = v;
    in_data  = d;
    in_dest  = m;
    ack      = a;
    @(posedge clk);
    acc_last = 0;
    if (rst_n) model_edge();
    #1;
    compare_outputs();
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_dest",     32'(dest),     32'h0);
    check("rst_busy",     32'(busy),     32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_sent",     32'(sent),     32'h0);
  endtask

  initial begin
    int tries;
    in_valid = 0; in_data = '0; in_dest = '0; ack = '0;
    rst_n = 1'b0;
    model_reset();
    cyc(0, 8'h00, 4'h0, 4'h0);
    cyc(0, 8'h00, 4'h0, 4'h0);
    rst_n = 1'b1;
    cyc(0, 8'h00, 4'h0, 4'h0);

    // Unicast
    cyc(1, 8'h42, 4'b0001, 4'b0000);
    cyc(0, 8'h00, 4'h0, 4'b0000);
    cyc(0, 8'h00, 4'h0, 4'b0001);
    cyc(0, 8'h00, 4'h0, 4'b0000);

    // Multicast with partial acks
    cyc(1, 8'h20, 4'b1011, 4'b0000);
    cyc(0, 8'h00, 4'h0, 4'b0000);
    cyc(0, 8'h00, 4'h0, 4'b0001);
    cyc(0, 8'h00, 4'h0, 4'b1000);
    cyc(0, 8'h00, 4'h0, 4'b0010);
    cyc(0, 8'h00, 4'h0, 4'b0000);

    // Spurious acks outside the pending mask
    cyc(1, 8'h33, 4'b0100, 4'b0000);
    cyc(0, 8'h00, 4'h0, 4'b0000);
    repeat (3) cyc(0, 8'h00, 4'h0, 4'b1011);
    cyc(0, 8'h00, 4'h0, 4'b0100);
    cyc(0, 8'h00, 4'h0, 4'b0000);

    // Full FIFO, then drain with full acks across pointer wrap
    for (int i = 0; i < 4; i++) cyc(1, 8'h10 + 8'(i), 4'(i + 1), 4'h0);
    repeat (3) cyc(1, 8'h14, 4'b0110, 4'h0);
    tries = 0;
    do begin
      cyc(1, 8'h14, 4'b0110, 4'hF);
      tries++;
    end while (!acc_last && tries < 10);
    check("fifth_accepted", 32'(acc_last), 32'h1);
    repeat (8) cyc(0, 8'h00, 4'h0, 4'hF);

    // Drop
    cyc(1, 8'h55, 4'b0000, 4'h0);
    repeat (3) cyc(0, 8'h00, 4'h0, 4'h0);
`ifdef NOC_TX_STATS_EN
    check("drop_cnt", 32'(drop_cnt), 32'(drops_m));
    check("sent_cnt", 32'(sent_cnt), 32'(sents_m));
`endif

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom_range(0, 15)),
          ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15)));
    end
    repeat (20) cyc(0, 8'h00, 4'h0, 4'hF);
`ifdef NOC_TX_STATS_EN
    check("drop_cnt_rand", 32'(drop_cnt), 32'(drops_m));
    check("sent_cnt_rand", 32'(sent_cnt), 32'(sents_m));
`endif

    // Reset mid-flight
    cyc(1, 8'hA1, 4'b0011, 4'h0);
    cyc(1, 8'hA2, 4'b0101, 4'h0);
    cyc(1, 8'hA3, 4'b1001, 4'h0);
    cyc(0, 8'h00, 4'h0, 4'h0);
    check("busy_before_rst", 32'(busy), 32'h1);
    #3;
    reset_now();
    cyc(0, 8'h00, 4'h0, 4'hF);
    cyc(0, 8'h00, 4'h0, 4'hF);
    rst_n = 1'b1;
    repeat (6) cyc(0, 8'h00, 4'h0, 4'hF);
    cyc(1, 8'h77, 4'b1000, 4'h0);
    cyc(0, 8'h00, 4'h0, 4'h0);
    cyc(0, 8'h00, 4'h0, 4'b1000);
    cyc(0, 8'h00, 4'h0, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
